lobster_dbus_arbiter: RTL and testbench
=======================================

// Module: lobster_dbus_arbiter
// PURPOSE
//  Owns the single SRAM port (ce/we/rdy/addr/data) of lobster_CPU and shares it
//  between three requesters: instruction fetch (execman), load buffer, store buffer.
//  Serialises one transaction at a time, drives the DBUS_* mode code, returns
//  read data/acks tagged by source, and guarantees forward progress for data-side traffic.
// PARAMETERS
//  ADDR_WIDTH       36   SRAM address width
//  DATA_WIDTH       64   SRAM data width
//  TAG_WIDTH        6    load tag width (matches 64-entry load buffer index)
//  MAX_FETCH_BURST  4    consecutive fetch grants allowed while load/store pending (>=1)
//  TIMEOUT          255  BUSY cycles without mem_rdy before abort (>=1)
// PORTS
//  clk          in   1           clock, all state on rising edge
//  rst          in   1           reset, asynchronous, active-low
//  fetch_req    in   1           fetch request, held until fetch_gnt
//  fetch_addr   in   ADDR_WIDTH  fetch address
//  fetch_gnt    out  1           1-cycle pulse: fetch request accepted
//  load_req     in   1           load request, held until load_gnt
//  load_addr    in   ADDR_WIDTH  load address
//  load_tag     in   TAG_WIDTH   load buffer slot, echoed on rsp_tag
//  load_gnt     out  1           1-cycle pulse: load accepted
//  store_req    in   1           store request, held until store_gnt
//  store_urgent in   1           store buffer full: store takes top priority
//  store_addr   in   ADDR_WIDTH  store address
//  store_data   in   DATA_WIDTH  store data
//  store_gnt    out  1           1-cycle pulse: store accepted
//  mem_ce       out  1           SRAM command enable
//  mem_we       out  1           SRAM write enable
//  mem_addr     out  ADDR_WIDTH  SRAM address
//  mem_wdata    out  DATA_WIDTH  SRAM write data
//  mem_rdata    in   DATA_WIDTH  SRAM read data, valid when mem_rdy=1
//  mem_rdy      in   1           SRAM done, sampled only in BUSY
//  rsp_valid    out  1           1-cycle pulse: transaction finished
//  rsp_src      out  2           DBUS code of finished transaction (01 F,10 L,11 S)
//  rsp_tag      out  TAG_WIDTH   load_tag of finished load, else 0
//  rsp_data     out  DATA_WIDTH  read data (loads/fetches), 0 for stores/errors
//  rsp_err      out  1           with rsp_valid: transaction timed out
//  dbus_mode    out  2           00 NOP,01 FETCH,10 LOAD,11 STORE; current BUSY kind
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; all outputs 0; burst and timeout counters 0.
//    Reset during BUSY aborts silently: mem_ce/mem_we drop immediately, no rsp_valid.
//  - FSM IDLE/BUSY, all outputs registered.
//  - IDLE, any req at edge: pick winner, latch addr/wdata/tag/kind, state<=BUSY,
//    mem_ce<=1, mem_we<=(store), winner gnt<=1 for exactly one cycle, dbus_mode<=kind.
//  - Priority: store_urgent&store_req > forced data-side > fetch > load > store.
//    Forced data-side: burst_cnt==MAX_FETCH_BURST and (load_req|store_req); load before store.
//  - burst_cnt: +1 on fetch grant while load_req|store_req; cleared on load/store grant
//    or when neither load_req nor store_req; saturates at MAX_FETCH_BURST.
//  - BUSY: mem_ce=1, addr/wdata/we held stable. mem_rdy=1 at edge -> state IDLE,
//    mem_ce/mem_we<=0, dbus_mode<=00, rsp_valid<=1 with src/tag, rsp_data<=mem_rdata
//    (0 for store), rsp_err<=0. Min latency: grant edge N, ce cycles N+1.., rsp 1 cycle
//    after rdy; peak one transaction per 2 cycles (IDLE cycle between).
//  - Timeout: to_cnt counts BUSY cycles, cleared on entry; reaching TIMEOUT without
//    mem_rdy -> IDLE, ce=0, rsp_valid=1, rsp_err=1, rsp_data=0. mem_rdy on the same
//    edge as expiry wins (normal completion).
//  - mem_rdy in IDLE ignored. Req dropped before gnt is legal (no grant issued).
//  - gnt, rsp_valid, rsp_err one-cycle pulses; rsp_src/tag/data hold until next rsp.
// TESTING
//  1 fetch_addr=0x000001000 only, mem_rdy on 3rd BUSY cycle, rdata=0x0123456789ABCDEF
//    -> fetch_gnt cyc1, mem_ce cyc1-3, rsp_valid cyc4 src=01 data=0x0123456789ABCDEF.
//  2 fetch,load(tag=5),store held continuously, rdy immediate, MAX_FETCH_BURST=4
//    -> grant order F,F,F,F,L,F,F,F,F,S; load rsp_tag=5.
//  3 fetch_req and store_req+store_urgent same cycle, store_data=0xCAFE
//    -> store first, mem_we=1, mem_wdata=0xCAFE, rsp_src=11 data=0; fetch next.
//  4 load issued, mem_rdy never -> ce drops after 255 BUSY cycles, rsp_err=1, data=0;
//    repeat with rdy on cycle 255 -> normal rsp, rsp_err=0.
//  5 rst=0 mid-BUSY -> mem_ce=0 asynchronously, no rsp_valid; after release fetch works.
//  6 mem_rdy pulsed while IDLE, no reqs -> no ce, no rsp_valid, dbus_mode stays 00.

Source files
------------

// File: rtl/lobster_dbus_arbiter.sv
// lobster_dbus_arbiter: shares the single SRAM port between fetch, load and store requesters.
// One transaction at a time; every output is registered.
module lobster_dbus_arbiter #(
    parameter int ADDR_WIDTH      = 36,
    parameter int DATA_WIDTH      = 64,
    parameter int TAG_WIDTH       = 6,
    parameter int MAX_FETCH_BURST = 4,
    parameter int TIMEOUT         = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_gnt,
    input  logic                  load_req,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [TAG_WIDTH-1:0]  load_tag,
    output logic                  load_gnt,
    input  logic                  store_req,
    input  logic                  store_urgent,
    input  logic [ADDR_WIDTH-1:0] store_addr,
    input  logic [DATA_WIDTH-1:0] store_data,
    output logic                  store_gnt,
    output logic                  mem_ce,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rdy,
    output logic                  rsp_valid,
    output logic [1:0]            rsp_src,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic [1:0]            dbus_mode
);
    localparam int BW = $clog2(MAX_FETCH_BURST + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] NOP = 2'b00, FETCH = 2'b01, LOAD = 2'b10, STORE = 2'b11;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state, state_n;
    logic [BW-1:0]         burst_cnt, burst_n;
    logic [TW-1:0]         to_cnt, to_n;
    logic [TAG_WIDTH-1:0]  cur_tag, cur_tag_n;
    logic                  fetch_gnt_n, load_gnt_n, store_gnt_n, mem_ce_n, mem_we_n;
    logic [ADDR_WIDTH-1:0] mem_addr_n;
    logic [DATA_WIDTH-1:0] mem_wdata_n, rsp_data_n;
    logic                  rsp_valid_n, rsp_err_n;
    logic [1:0]            rsp_src_n, dbus_mode_n, pick, win;
    logic [TAG_WIDTH-1:0]  rsp_tag_n;
    logic                  data_pend, forced, expire;

    assign data_pend = load_req | store_req;
    assign forced    = (burst_cnt == BW'(MAX_FETCH_BURST)) && data_pend;
    assign expire    = to_cnt == TW'(TIMEOUT - 1);
    // Urgent store beats everything; a saturated fetch burst yields to data-side traffic.
    assign pick = (store_urgent && store_req) ? STORE :
                  forced    ? (load_req ? LOAD : STORE) :
                  fetch_req ? FETCH :
                  load_req  ? LOAD :
                  store_req ? STORE : NOP;
    assign win = (state == IDLE) ? pick : NOP;

    always_comb begin
        state_n     = state;
        to_n        = to_cnt;
        cur_tag_n   = cur_tag;
        fetch_gnt_n = win == FETCH;
        load_gnt_n  = win == LOAD;
        store_gnt_n = win == STORE;
        mem_ce_n    = mem_ce;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        dbus_mode_n = dbus_mode;
        rsp_valid_n = 1'b0;
        rsp_err_n   = 1'b0;
        rsp_src_n   = rsp_src;
        rsp_tag_n   = rsp_tag;
        rsp_data_n  = rsp_data;
        burst_n     = !data_pend ? '0 :
                      (win == LOAD || win == STORE) ? '0 :
                      (win == FETCH && burst_cnt != BW'(MAX_FETCH_BURST)) ? burst_cnt + BW'(1) :
                      burst_cnt;
        if (win != NOP) begin
            state_n     = BUSY;
            to_n        = '0;
            cur_tag_n   = load_tag;
            mem_ce_n    = 1'b1;
            mem_we_n    = win == STORE;
            mem_addr_n  = win == FETCH ? fetch_addr : win == LOAD ? load_addr : store_addr;
            mem_wdata_n = win == STORE ? store_data : '0;
            dbus_mode_n = win;
        end else if (state == BUSY) begin
            if (mem_rdy || expire) begin
                state_n     = IDLE;
                mem_ce_n    = 1'b0;
                mem_we_n    = 1'b0;
                dbus_mode_n = NOP;
                rsp_valid_n = 1'b1;
                rsp_err_n   = !mem_rdy;
                rsp_src_n   = dbus_mode;
                rsp_tag_n   = dbus_mode == LOAD ? cur_tag : '0;
                rsp_data_n  = (mem_rdy && dbus_mode != STORE) ? mem_rdata : '0;
            end else begin
                to_n = to_cnt + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            burst_cnt <= '0;
            to_cnt    <= '0;
            cur_tag   <= '0;
            fetch_gnt <= 1'b0;
            load_gnt  <= 1'b0;
            store_gnt <= 1'b0;
            mem_ce    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_src   <= '0;
            rsp_tag   <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            dbus_mode <= NOP;
        end else begin
            state     <= state_n;
            burst_cnt <= burst_n;
            to_cnt    <= to_n;
            cur_tag   <= cur_tag_n;
            fetch_gnt <= fetch_gnt_n;
            load_gnt  <= load_gnt_n;
            store_gnt <= store_gnt_n;
            mem_ce    <= mem_ce_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            rsp_valid <= rsp_valid_n;
            rsp_src   <= rsp_src_n;
            rsp_tag   <= rsp_tag_n;
            rsp_data  <= rsp_data_n;
            rsp_err   <= rsp_err_n;
            dbus_mode <= dbus_mode_n;
        end
    end
endmodule

// File: tb/tb_lobster_dbus_arbiter.sv
// tb_lobster_dbus_arbiter: directed self-checking bench for lobster_dbus_arbiter.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_lobster_dbus_arbiter;
    logic        clk = 1'b0, rst = 1'b0;
    logic        fetch_req = 1'b0, load_req = 1'b0, store_req = 1'b0, store_urgent = 1'b0;
    logic [35:0] fetch_addr = '0, load_addr = '0, store_addr = '0;
    logic [5:0]  load_tag = '0;
    logic [63:0] store_data = '0, mem_rdata = '0;
    logic        mem_rdy = 1'b0;
    logic        fetch_gnt, load_gnt, store_gnt, mem_ce, mem_we, rsp_valid, rsp_err;
    logic [35:0] mem_addr;
    logic [63:0] mem_wdata, rsp_data;
    logic [1:0]  rsp_src, dbus_mode;
    logic [5:0]  rsp_tag;
    int checks = 0, errors = 0;

    lobster_dbus_arbiter dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .load_req(load_req), .load_addr(load_addr), .load_tag(load_tag), .load_gnt(load_gnt),
        .store_req(store_req), .store_urgent(store_urgent), .store_addr(store_addr),
        .store_data(store_data), .store_gnt(store_gnt),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
        .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .dbus_mode(dbus_mode)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [1:0] got [10];
    logic [1:0] exp2 [10];
    logic [1:0] g;
    int n;

    initial begin
        exp2 = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3};
        // reset state
        step; step;
        chk("rst_ce", {63'd0, mem_ce}, 64'd0);
        chk("rst_mode", {62'd0, dbus_mode}, 64'd0);
        chk("rst_rsp", {63'd0, rsp_valid}, 64'd0);
        chk("rst_gnt", {61'd0, fetch_gnt, load_gnt, store_gnt}, 64'd0);
        rst = 1'b1;
        step;

        // 1: lone fetch, rdy on third BUSY cycle
        fetch_addr = 36'h000001000;
        fetch_req = 1'b1;
        step;
        chk("t1_gnt", {63'd0, fetch_gnt}, 64'd1);
        chk("t1_ce1", {63'd0, mem_ce}, 64'd1);
        chk("t1_addr", {28'd0, mem_addr}, 64'h1000);
        chk("t1_mode", {62'd0, dbus_mode}, 64'd1);
        fetch_req = 1'b0;
        step;
        chk("t1_gnt_pulse", {63'd0, fetch_gnt}, 64'd0);
        chk("t1_ce2", {63'd0, mem_ce}, 64'd1);
        step;
        chk("t1_ce3", {63'd0, mem_ce}, 64'd1);
        chk("t1_norsp", {63'd0, rsp_valid}, 64'd0);
        mem_rdy = 1'b1;
        mem_rdata = 64'h0123456789ABCDEF;
        step;
        mem_rdy = 1'b0;
        chk("t1_rsp", {63'd0, rsp_valid}, 64'd1);
        chk("t1_src", {62'd0, rsp_src}, 64'd1);
        chk("t1_data", rsp_data, 64'h0123456789ABCDEF);
        chk("t1_ce_off", {63'd0, mem_ce}, 64'd0);
        chk("t1_mode_off", {62'd0, dbus_mode}, 64'd0);
        step;
        chk("t1_rsp_pulse", {63'd0, rsp_valid}, 64'd0);
        chk("t1_data_hold", rsp_data, 64'h0123456789ABCDEF);

        // 2: fetch burst limit with load and store pending
        fetch_addr = 36'h2000; load_addr = 36'h3000; store_addr = 36'h4000;
        load_tag = 6'd5;
        fetch_req = 1'b1; load_req = 1'b1; store_req = 1'b1;
        n = 0;
        for (int c = 0; c < 80 && n < 10; c++) begin
            step;
            g = fetch_gnt ? 2'd1 : load_gnt ? 2'd2 : store_gnt ? 2'd3 : 2'd0;
            if (g != 2'd0 && n < 10) begin
                got[n] = g;
                n++;
            end
            if (load_gnt) load_req = 1'b0;
            if (store_gnt) store_req = 1'b0;
            if (n == 10) fetch_req = 1'b0;
            if (rsp_valid && rsp_src == 2'b10) chk("t2_tag", {58'd0, rsp_tag}, 64'd5);
            mem_rdy = mem_ce;
        end
        chk("t2_count", 64'(n), 64'd10);
        for (int i = 0; i < 10; i++) chk($sformatf("t2_order%0d", i), {62'd0, got[i]}, {62'd0, exp2[i]});
        step;
        mem_rdy = 1'b0;
        step;

        // 3: urgent store beats simultaneous fetch
        fetch_req = 1'b1; store_req = 1'b1; store_urgent = 1'b1;
        store_data = 64'hCAFE;
        step;
        chk("t3_sgnt", {63'd0, store_gnt}, 64'd1);
        chk("t3_fgnt", {63'd0, fetch_gnt}, 64'd0);
        chk("t3_we", {63'd0, mem_we}, 64'd1);
        chk("t3_wdata", mem_wdata, 64'hCAFE);
        chk("t3_mode", {62'd0, dbus_mode}, 64'd3);
        store_req = 1'b0; store_urgent = 1'b0;
        mem_rdy = 1'b1; mem_rdata = 64'hDEAD;
        step;
        mem_rdy = 1'b0;
        chk("t3_rsp", {63'd0, rsp_valid}, 64'd1);
        chk("t3_src", {62'd0, rsp_src}, 64'd3);
        chk("t3_data", rsp_data, 64'd0);
        step;
        chk("t3_fetch_next", {63'd0, fetch_gnt}, 64'd1);
        fetch_req = 1'b0;
        mem_rdy = 1'b1;
        step;
        mem_rdy = 1'b0;
        step;

        // 4a: load with no mem_rdy times out after 255 BUSY cycles
        load_req = 1'b1; load_tag = 6'd7; mem_rdata = 64'h55AA;
        step;
        chk("t4_gnt", {63'd0, load_gnt}, 64'd1);
        load_req = 1'b0;
        for (int i = 0; i < 254; i++) step;
        chk("t4_ce255", {63'd0, mem_ce}, 64'd1);
        step;
        chk("t4_ce_off", {63'd0, mem_ce}, 64'd0);
        chk("t4_rsp", {63'd0, rsp_valid}, 64'd1);
        chk("t4_err", {63'd0, rsp_err}, 64'd1);
        chk("t4_data", rsp_data, 64'd0);
        chk("t4_tag", {58'd0, rsp_tag}, 64'd7);
        step;
        chk("t4_err_pulse", {63'd0, rsp_err}, 64'd0);

        // 4b: mem_rdy on the expiry cycle completes normally
        load_req = 1'b1;
        step;
        load_req = 1'b0;
        for (int i = 0; i < 254; i++) step;
        mem_rdy = 1'b1;
        step;
        mem_rdy = 1'b0;
        chk("t4b_rsp", {63'd0, rsp_valid}, 64'd1);
        chk("t4b_err", {63'd0, rsp_err}, 64'd0);
        chk("t4b_data", rsp_data, 64'h55AA);
        step;

        // 5: asynchronous reset mid-BUSY
        fetch_req = 1'b1;
        step;
        fetch_req = 1'b0;
        chk("t5_ce_busy", {63'd0, mem_ce}, 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("t5_ce_async", {63'd0, mem_ce}, 64'd0);
        chk("t5_mode_async", {62'd0, dbus_mode}, 64'd0);
        step;
        chk("t5_norsp1", {63'd0, rsp_valid}, 64'd0);
        rst = 1'b1;
        step;
        chk("t5_norsp2", {63'd0, rsp_valid}, 64'd0);
        fetch_req = 1'b1;
        step;
        chk("t5_fetch_gnt", {63'd0, fetch_gnt}, 64'd1);
        fetch_req = 1'b0;
        mem_rdy = 1'b1;
        step;
        mem_rdy = 1'b0;
        chk("t5_fetch_rsp", {63'd0, rsp_valid}, 64'd1);
        step;

        // 6: mem_rdy in IDLE is ignored
        mem_rdy = 1'b1;
        step;
        chk("t6_ce", {63'd0, mem_ce}, 64'd0);
        chk("t6_rsp", {63'd0, rsp_valid}, 64'd0);
        step;
        chk("t6_rsp2", {63'd0, rsp_valid}, 64'd0);
        chk("t6_mode", {62'd0, dbus_mode}, 64'd0);
        mem_rdy = 1'b0;
        step;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
